// File: rtl/bash_hash_params_pkg.sv
// Shared widths, AXI response codes and the AXI4-Lite master controller state type.
package bash_hash_params_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDRLEN = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } axil_state_e;

  // States in which the wait counter advances.
  function automatic logic axil_state_busy(input axil_state_e s);
    return (s == ST_WRITE) || (s == ST_WRESP) || (s == ST_RADDR) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/axi4_lite_master_ctrl_if.sv
// AXI4-Lite bus bundle (no PROT signals) with master and slave views.
interface axi4_lite_master_ctrl_if;
  import bash_hash_params_pkg::*;

  logic [ADDRLEN-1:0] m_axi_awaddr;
  logic               m_axi_awvalid;
  logic               m_axi_awready;

  logic [XLEN-1:0]    m_axi_wdata;
  logic [3:0]         m_axi_wstrb;
  logic               m_axi_wvalid;
  logic               m_axi_wready;

  logic [1:0]         m_axi_bresp;
  logic               m_axi_bvalid;
  logic               m_axi_bready;

  logic [ADDRLEN-1:0] m_axi_araddr;
  logic               m_axi_arvalid;
  logic               m_axi_arready;

  logic [XLEN-1:0]    m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rvalid;
  logic               m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: accepts one command, runs the AXI
// handshakes, returns the response and flags transactions that wait too long.
module axi4_lite_master_ctrl
  import bash_hash_params_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,

  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [ADDRLEN-1:0]     cmd_addr_i,
  input  logic [XLEN-1:0]        cmd_wdata_i,
  input  logic [3:0]             cmd_wstrb_i,

  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [XLEN-1:0]        rsp_rdata_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   timeout_o,

  axi4_lite_master_ctrl_if.master m_axi
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  axil_state_e        r_state;
  axil_state_e        w_state_nxt;

  logic [ADDRLEN-1:0] r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_aw_done;
  logic               r_w_done;
  logic [XLEN-1:0]    r_rdata;
  logic [1:0]         r_resp;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_consume;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_aw_hs   = m_axi.m_axi_awvalid && m_axi.m_axi_awready;
  assign w_w_hs    = m_axi.m_axi_wvalid && m_axi.m_axi_wready;
  assign w_consume = (r_state == ST_RSP) && rsp_ready_i;

  // Every AXI output is decoded from registers only, so no AXI input reaches an AXI output.
  assign cmd_ready_o         = (r_state == ST_IDLE);
  assign m_axi.m_axi_awvalid = (r_state == ST_WRITE) && !r_aw_done;
  assign m_axi.m_axi_wvalid  = (r_state == ST_WRITE) && !r_w_done;
  assign m_axi.m_axi_bready  = (r_state == ST_WRESP);
  assign m_axi.m_axi_arvalid = (r_state == ST_RADDR);
  assign m_axi.m_axi_rready  = (r_state == ST_RDATA);
  assign m_axi.m_axi_awaddr  = r_addr;
  assign m_axi.m_axi_araddr  = r_addr;
  assign m_axi.m_axi_wdata   = r_wdata;
  assign m_axi.m_axi_wstrb   = r_wstrb;

  assign rsp_valid_o = (r_state == ST_RSP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_resp_o  = r_resp;
  assign timeout_o   = (r_cnt >= CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = cmd_write_i ? ST_WRITE : ST_RADDR;
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; leave once both have, in either order.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_axi.m_axi_bvalid) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RADDR: begin
        if (m_axi.m_axi_arready) begin
          w_state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi.m_axi_rvalid) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= cmd_addr_i;
        r_wdata   <= cmd_wdata_i;
        r_wstrb   <= cmd_wstrb_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == ST_WRITE) begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
        end
      end
      if ((r_state == ST_WRESP) && m_axi.m_axi_bvalid) begin
        r_rdata <= '0;
        r_resp  <= m_axi.m_axi_bresp;
      end
      if ((r_state == ST_RDATA) && m_axi.m_axi_rvalid) begin
        r_rdata <= m_axi.m_axi_rdata;
        r_resp  <= m_axi.m_axi_rresp;
      end
    end
  end

  // Wait counter: zero in IDLE, counts busy cycles, holds through RSP.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_cnt <= '0;
    end else if (w_accept || w_consume) begin
      r_cnt <= '0;
    end else if (axil_state_busy(r_state) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
